inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
- Instruction prefetch stage sitting directly upstream of the control unit's instruction path.
- Autonomously fetches sequential instruction words from the memory interface into a small queue.
- Presents them to the consumer with a valid/ready handshake, each word tagged with its PC.
- Supports redirect (branch/jump): flushes queued words and restarts fetch at a new PC, safely absorbing any in-flight memory response.

Parameters:
ADDR_WIDTH, 16, instruction address width (word-addressed)
INST_WIDTH, 16, instruction word width
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_redirect_valid  input  1  one-cycle pulse: flush and restart at i_redirect_pc
i_redirect_pc  input  ADDR_WIDTH  new fetch address
o_mem_req  output  1  memory read request, held until acked
o_mem_addr  output  ADDR_WIDTH  request address, stable while o_mem_req=1
i_mem_ack  input  1  completes current request; i_mem_data valid this cycle
i_mem_data  input  INST_WIDTH  returned instruction word
o_inst_valid  output  1  queue head valid
o_inst  output  INST_WIDTH  queue head instruction
o_inst_pc  output  ADDR_WIDTH  address of o_inst
i_inst_ready  input  1  consumer accepts head when o_inst_valid=1

Behaviour:
- Reset (rst=1 at edge):
  - o_mem_req=0, o_mem_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0.
  - Queue count=0, fetch_pc=RESET_PC, state IDLE.
  - Reset mid-transaction abandons everything; a stale i_mem_ack arriving while o_mem_req=0 is ignored.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: if (count + pending) < DEPTH and no redirect -> REQ next cycle, o_mem_req=1, o_mem_addr=fetch_pc.
  - REQ: o_mem_req=1, address held constant until i_mem_ack.
    - On ack: write {fetch_pc, i_mem_data} to tail; fetch_pc <= fetch_pc+1 (wraps mod 2^ADDR_WIDTH).
    - If space remains after the push, stay in REQ with the new address (back-to-back, one request per ack); else go to IDLE.
  - REQ + i_redirect_valid, no ack same cycle: -> DISCARD. o_mem_req stays 1 with the old address.
  - DISCARD: on i_mem_ack, drop the data and go to IDLE (REQ issued the following cycle).
- Redirect, any state:
  - Queue count <= 0 and fetch_pc <= i_redirect_pc next cycle.
  - o_inst_valid=0 the cycle after redirect.
  - Redirect in DISCARD updates fetch_pc again; state stays DISCARD.
- Redirect and ack in the same cycle (REQ): ack data discarded, no push; next state IDLE; new request at i_redirect_pc one cycle later.
- Redirect and pop in the same cycle: redirect wins, flush applies. The consumer must treat the word as not taken.
- Credit rule: pending (0/1) counts the outstanding request, so a push can never overflow. Push when full is impossible by construction; an assertion must check it.
- Pop: o_inst_valid & i_inst_ready removes the head. Simultaneous push and pop leave count unchanged.
- Head outputs: o_inst_valid = (count != 0); o_inst and o_inst_pc are driven from the head entry. Outputs are held stable while valid && !ready.
- Latency:
  - Request issued cycle N, ack cycle M>=N: word visible at head cycle M+1 if the queue was empty.
  - After redirect in IDLE/REQ without an outstanding request: new o_mem_req one cycle later.

Decomposition:
- define.v: FSM state encodings (IPQ_IDLE, IPQ_REQ, IPQ_DISCARD) and default ADDR_WIDTH/INST_WIDTH macros.
- Sub-module sync_fifo:
  - Parameterised width/depth; push/pop/flush inputs, count output.
  - Stores {pc, inst}, width ADDR_WIDTH+INST_WIDTH.
- The top holds the FSM, fetch_pc and credit logic.

Test Plan:
- Reset release, memory acks every request one cycle after issue, consumer always ready -> addresses 0,1,2,3... issued; o_inst_pc sequence 0,1,2,...; o_inst matches memory image; no gaps after the first word.
- Consumer ready=0 -> exactly DEPTH=4 requests issued (addr 0-3); o_mem_req then stays 0; head holds pc 0 stable. Raising ready resumes fetch at addr 4.
- Redirect to 0x0100 while the queue holds 3 words and no request outstanding -> o_inst_valid=0 next cycle; next request addr 0x0100; first delivered o_inst_pc=0x0100.
- Redirect to 0x0200 while a request to addr 5 is unacked; ack arrives 3 cycles later -> addr 5 data never appears at output; next request addr 0x0200.
- Redirect and ack in the same cycle, plus a second redirect to 0x0300 during DISCARD -> only 0x0300 stream delivered.
- Fetch from addr 0xFFFE with ADDR_WIDTH=16 -> o_inst_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- Assert rst mid-REQ -> all outputs at reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and default widths for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

  localparam int IPQ_ADDR_W = 16;
  localparam int IPQ_INST_W = 16;

  typedef enum logic [1:0] {
    IPQ_IDLE    = 2'd0,
    IPQ_REQ     = 2'd1,
    IPQ_DISCARD = 2'd2
  } ipq_state_e;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head word is always visible on dout.
module inst_prefetch_queue_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;

  // Storage is left unreset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory read at a time,
// queued words tagged with their PC, redirect flushes and restarts fetch.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH = IPQ_ADDR_W,
  parameter int                    INST_WIDTH = IPQ_INST_W,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [INST_WIDTH-1:0] i_mem_data,
  output logic                  o_inst_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  input  logic                  i_inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW-1:0]         FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;

  ipq_state_e            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [EW-1:0]         head;
  logic                  push;
  logic                  pop;

  // A redirect kills both the returning word and any same-cycle pop.
  assign push = (state == IPQ_REQ) && i_mem_ack && !i_redirect_valid;
  assign pop  = o_inst_valid && i_inst_ready && !i_redirect_valid;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IPQ_IDLE;
      fetch_pc   <= RESET_PC;
      o_mem_req  <= 1'b0;
      o_mem_addr <= RESET_PC;
    end else begin
      if (i_redirect_valid) fetch_pc <= i_redirect_pc;
      case (state)
        // Nothing is outstanding in IDLE, so the credit check is just count.
        IPQ_IDLE: begin
          if (!i_redirect_valid && count < FULL) begin
            state      <= IPQ_REQ;
            o_mem_req  <= 1'b1;
            o_mem_addr <= fetch_pc;
          end
        end
        IPQ_REQ: begin
          if (i_mem_ack) begin
            if (i_redirect_valid) begin
              state     <= IPQ_IDLE;
              o_mem_req <= 1'b0;
            end else begin
              fetch_pc <= fetch_pc + PC_ONE;
              if (count_nxt < FULL) begin
                o_mem_addr <= fetch_pc + PC_ONE;
              end else begin
                state     <= IPQ_IDLE;
                o_mem_req <= 1'b0;
              end
            end
          end else if (i_redirect_valid) begin
            state <= IPQ_DISCARD;
          end
        end
        IPQ_DISCARD: begin
          if (i_mem_ack) begin
            state     <= IPQ_IDLE;
            o_mem_req <= 1'b0;
          end
        end
        default: begin
          state     <= IPQ_IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

  inst_prefetch_queue_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect_valid),
    .din   ({fetch_pc, i_mem_data}),
    .dout  (head),
    .count (count)
  );

  assign o_inst_valid = (count != '0);
  assign o_inst_pc    = o_inst_valid ? head[EW-1:INST_WIDTH] : '0;
  assign o_inst       = o_inst_valid ? head[INST_WIDTH-1:0]  : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized scoreboard bench: the expected delivered stream is the
// sequential PC run starting at the last reset/redirect target.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_redirect_valid;
  logic [15:0] i_redirect_pc;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic        o_inst_valid;
  logic [15:0] o_inst;
  logic [15:0] o_inst_pc;
  logic        i_inst_ready;

  inst_prefetch_queue #(
    .ADDR_WIDTH (16),
    .INST_WIDTH (16),
    .DEPTH      (4),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ack        (i_mem_ack),
    .i_mem_data       (i_mem_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_next;
  int          delivered = 0;
  int          acked = 0;
  int          lat_cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          mem_manual = 0;
  bit          stale_en = 0;
  bit          saw_wrap = 0;
  logic [15:0] last_pc = 16'h0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_fill();
    while (exp_q.size() < 32) begin
      exp_q.push_back(sb_next);
      sb_next = sb_next + 16'd1;
    end
  endtask

  task automatic sb_restart(input logic [15:0] pc);
    exp_q.delete();
    sb_next = pc;
    sb_fill();
  endtask

  // Advance one cycle; inputs change 1ns after the edge, memory model responds.
  task automatic tick();
    @(posedge clk);
    #1;
    i_redirect_valid = 1'b0;
    i_mem_ack        = 1'b0;
    i_mem_data       = 16'($urandom);
    if (!mem_manual) begin
      if (o_mem_req) begin
        if (lat_cnt == 0) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_word(o_mem_addr);
          acked++;
          lat_cnt = $urandom_range(lat_lo, lat_hi);
        end else begin
          lat_cnt--;
        end
      end else if (stale_en && $urandom_range(0, 7) == 0) begin
        i_mem_ack = 1'b1;
      end
    end
    sb_fill();
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
    sb_restart(pc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    sb_restart(16'h0000);
    chk("rst_mem_req",  o_mem_req,    0);
    chk("rst_mem_addr", o_mem_addr,   0);
    chk("rst_valid",    o_inst_valid, 0);
    chk("rst_inst",     o_inst,       0);
    chk("rst_inst_pc",  o_inst_pc,    0);
    rst = 1'b0;
    lat_cnt = lat_lo;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!o_mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!o_mem_req) begin
      tests++;
      fails++;
      $display("FAIL %s: no memory request within 20 cycles", nm);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, checks protocol rules.
  logic        p_req = 0, p_redir = 0, p_vhold = 0;
  logic [15:0] p_addr, p_pc, p_inst;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        p_req = 0; p_redir = 0; p_vhold = 0;
      end else begin
        if (p_redir) chk("valid_after_redirect", o_inst_valid, 0);
        if (p_req) begin
          chk("mem_req_held",  o_mem_req,  1);
          chk("mem_addr_held", o_mem_addr, p_addr);
        end
        if (p_vhold) begin
          chk("head_valid_held", o_inst_valid, 1);
          chk("head_pc_stable",  o_inst_pc,    p_pc);
          chk("head_inst_stable", o_inst,      p_inst);
        end
        if (o_inst_valid && i_inst_ready && !i_redirect_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got pc %0h expected none", o_inst_pc);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("pop_pc",   o_inst_pc, e);
            chk("pop_inst", o_inst,    mem_word(e));
          end
          if (last_pc == 16'hFFFF && o_inst_pc == 16'h0000) saw_wrap = 1;
          last_pc = o_inst_pc;
          delivered++;
        end
        p_req   = o_mem_req && !i_mem_ack;
        p_addr  = o_mem_addr;
        p_redir = i_redirect_valid;
        p_vhold = o_inst_valid && !i_inst_ready && !i_redirect_valid;
        p_pc    = o_inst_pc;
        p_inst  = o_inst;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_redirect_valid = 1'b0; i_redirect_pc = '0;
    i_mem_ack = 1'b0; i_mem_data = '0; i_inst_ready = 1'b0;
    sb_restart(16'h0000);
    repeat (2) tick();
    do_reset();

    // Streaming, ack one cycle after issue, consumer always ready.
    i_inst_ready = 1'b1;
    delivered = 0;
    repeat (40) tick();
    chk("stream_progress", 32'(delivered >= 15), 1);

    // Backpressure: exactly DEPTH fetches, then idle with head held.
    i_inst_ready = 1'b0;
    do_reset();
    acked = 0;
    repeat (20) tick();
    chk("bp_acks",     acked,        4);
    chk("bp_req_idle", o_mem_req,    0);
    chk("bp_valid",    o_inst_valid, 1);
    chk("bp_head_pc",  o_inst_pc,    0);
    i_inst_ready = 1'b1;
    tick();
    i_inst_ready = 1'b0;
    wait_req("resume");
    chk("resume_addr", o_mem_addr, 16'h0004);
    repeat (6) tick();
    chk("full_idle",      o_mem_req, 0);
    chk("head_after_pop", o_inst_pc, 16'h0001);

    // Redirect with a full queue and nothing outstanding.
    do_redirect(16'h0100);
    tick();
    chk("redir_valid_low", o_inst_valid, 0);
    wait_req("redir_0100");
    chk("redir_addr_0100", o_mem_addr, 16'h0100);
    i_inst_ready = 1'b1;
    delivered = 0;
    repeat (20) tick();
    chk("redir_0100_progress", 32'(delivered > 0), 1);

    // Redirect while a request is outstanding; late ack must be dropped.
    mem_manual = 1;
    wait_req("pend_req");
    do_redirect(16'h0200);
    tick();
    chk("discard_req_held", o_mem_req, 1);
    tick(); tick();
    i_mem_ack = 1'b1;
    i_mem_data = mem_word(o_mem_addr);
    tick();
    wait_req("post_discard");
    chk("post_discard_addr", o_mem_addr, 16'h0200);

    // Redirect + ack same cycle, then redirect twice around a DISCARD.
    i_mem_ack = 1'b1;
    i_mem_data = mem_word(o_mem_addr);
    do_redirect(16'h0280);
    tick();
    chk("ackredir_req_low", o_mem_req, 0);
    wait_req("ackredir");
    chk("ackredir_addr", o_mem_addr, 16'h0280);
    do_redirect(16'h02C0);
    tick();
    chk("discard_addr_old", o_mem_addr, 16'h0280);
    do_redirect(16'h0300);
    tick(); tick();
    i_mem_ack = 1'b1;
    i_mem_data = mem_word(o_mem_addr);
    tick();
    wait_req("redir_0300");
    chk("redir_addr_0300", o_mem_addr, 16'h0300);
    mem_manual = 0;
    lat_lo = 0; lat_hi = 2;
    delivered = 0;
    repeat (30) tick();
    chk("redir_0300_progress", 32'(delivered >= 5), 1);

    // Address wrap.
    saw_wrap = 0;
    do_redirect(16'hFFFE);
    repeat (20) tick();
    chk("wrap_seen", saw_wrap, 1);

    // Random traffic, stale acks, random redirects.
    stale_en = 1;
    lat_lo = 0; lat_hi = 3;
    delivered = 0;
    repeat (1500) begin
      tick();
      i_inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0)
        do_redirect(($urandom_range(0, 1) != 0) ? 16'($urandom) : (16'hFFF0 + 16'($urandom_range(0, 15))));
    end
    chk("random_progress", 32'(delivered > 300), 1);

    // Reset in the middle of an outstanding request.
    stale_en = 0;
    mem_manual = 1;
    wait_req("pre_reset");
    do_reset();
    wait_req("post_reset");
    chk("post_reset_addr", o_mem_addr, 16'h0000);
    mem_manual = 0;
    i_inst_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
